// File: rtl/seq_mult_iter_if.sv
// Handshake and operand/result bundle for the iterative multiplier.
// The master side issues start, mode and operands.
// The slave side (the multiplier) returns busy, done and the product.
interface seq_mult_iter_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_en;
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output start,
    output signed_en,
    output in1,
    output in2,
    input  busy,
    input  done,
    input  prod
  );

  modport slave (
    input  start,
    input  signed_en,
    input  in1,
    input  in2,
    output busy,
    output done,
    output prod
  );
endinterface

// File: rtl/seq_mult_iter.sv
// Multi-cycle shift-add multiplier that retires one multiplier bit per clock.
// Signed operation multiplies the magnitudes and fixes the sign once at the end.
// The product register keeps the last result until the next operation finishes.
module seq_mult_iter #(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_mult_iter_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;

  logic             in1_neg;
  logic             in2_neg;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    in1_neg = bus.signed_en & bus.in1[WIDTH-1];
    in2_neg = bus.signed_en & bus.in2[WIDTH-1];
    mag1    = in1_neg ? (~bus.in1 + WIDTH'(1)) : bus.in1;
    mag2    = in2_neg ? (~bus.in2 + WIDTH'(1)) : bus.in2;
  end

  // Next-state logic: capture in IDLE, one shift-add per cycle in CALC, sign fix-up in FINISH.
  always_comb begin
    state_d  = state_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    count_d  = count_q;
    neg_d    = neg_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mplier_d = mag1;
          mcand_d  = {{WIDTH{1'b0}}, mag2};
          neg_d    = in1_neg ^ in2_neg;
          acc_d    = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end

      CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        count_d  = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        prod_d  = neg_q ? (~acc_q + PW'(1)) : acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight and clears the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mplier_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.prod = prod_q;

endmodule

// File: tb/tb_seq_mult_iter.sv
// Scoreboard bench for seq_mult_iter, instantiated at widths 2, 8, 16, 32 and 64.
// Stimulus pushes expected products and completion cycles into per-instance queues.
// A negedge monitor pops and compares them whenever done is seen.
module tb_seq_mult_iter;

  localparam int NUM = 5;
  localparam int WL [NUM] = '{2, 8, 16, 32, 64};
  localparam int I8  = 1;
  localparam int I16 = 2;
  localparam int I32 = 3;

  typedef struct {
    logic [127:0] prod;
    longint       cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        start_a [NUM];
  logic        sgn_a   [NUM];
  logic [63:0] in1_a   [NUM];
  logic [63:0] in2_a   [NUM];
  wire         busy_a  [NUM];
  wire         done_a  [NUM];
  wire [127:0] prod_a  [NUM];

  exp_t         expq      [NUM][$];
  logic [127:0] last_prod [NUM];

  longint cyc    = 0;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  // Edge counter used to timestamp expected completions.
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NUM; g++) begin : g_dut
    localparam int W = WL[g];
    seq_mult_iter_if #(.WIDTH(W)) bus ();
    assign bus.start     = start_a[g];
    assign bus.signed_en = sgn_a[g];
    assign bus.in1       = in1_a[g][W-1:0];
    assign bus.in2       = in2_a[g][W-1:0];
    assign busy_a[g]     = bus.busy;
    assign done_a[g]     = bus.done;
    assign prod_a[g]     = 128'(bus.prod);
    seq_mult_iter #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  function automatic logic [63:0] opMask(int w);
    if (w >= 64) return '1;
    return (64'(1) << w) - 64'(1);
  endfunction

  // Reference product: interpret operands as integers and multiply, then keep 2*w bits.
  function automatic logic [127:0] refProd(int w, logic [63:0] a, logic [63:0] b, logic s);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    logic signed [127:0] p;
    logic        [127:0] m;
    logic        [63:0]  am;
    logic        [63:0]  bm;
    am = a & opMask(w);
    bm = b & opMask(w);
    sa = $signed({64'd0, am});
    sb = $signed({64'd0, bm});
    if (s) begin
      if (am[w-1]) sa = sa - (128'sd1 <<< w);
      if (bm[w-1]) sb = sb - (128'sd1 <<< w);
    end
    p = sa * sb;
    m = (w >= 64) ? '1 : ((128'(1) << (2 * w)) - 128'(1));
    return p & m;
  endfunction

  function automatic logic [63:0] randOp(int w);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: r = '1;
      1: r = 64'(1) << (w - 1);
      2: r = '0;
      3: r = (64'(1) << (w - 1)) - 64'(1);
      default: ;
    endcase
    return r & opMask(w);
  endfunction

  task automatic checkOutput(string name, int idx, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (W=%0d): got %h, expected %h", name, WL[idx], act, exp);
    end
  endtask

  // Drive one request at the current negedge and record its expected completion.
  task automatic applyStimulus(int i, logic [63:0] a, logic [63:0] b, logic s, logic [127:0] e);
    exp_t x;
    in1_a[i]   = a;
    in2_a[i]   = b;
    sgn_a[i]   = s;
    start_a[i] = 1'b1;
    x.prod = e;
    x.cyc  = cyc + longint'(WL[i]) + 2;
    expq[i].push_back(x);
  endtask

  // Full operation ending on the negedge where done is visible.
  task automatic runOp(int i, logic [63:0] a, logic [63:0] b, logic s, logic [127:0] e);
    applyStimulus(i, a, b, s, e);
    @(negedge clk);
    start_a[i] = 1'b0;
    repeat (WL[i] + 1) @(negedge clk);
  endtask

  task automatic assertReset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      expq[i].delete();
      last_prod[i] = '0;
    end
  endtask

  // Monitor: pop on done, otherwise require the product to hold and flag overdue results.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      for (int i = 0; i < NUM; i++) begin
        if (done_a[i] === 1'b1) begin
          checkOutput("done_with_busy", i, 128'(busy_a[i]), 128'(0));
          if (expq[i].size() == 0) begin
            checkOutput("unexpected_done", i, 128'(done_a[i]), 128'(0));
          end else begin
            e = expq[i].pop_front();
            checkOutput("prod", i, prod_a[i], e.prod);
            checkOutput("latency", i, 128'(cyc), 128'(e.cyc));
            last_prod[i] = e.prod;
          end
        end else begin
          checkOutput("prod_hold", i, prod_a[i], last_prod[i]);
          if (expq[i].size() != 0 && cyc >= expq[i][0].cyc) begin
            checkOutput("missing_done", i, 128'(done_a[i]), 128'(1));
            e = expq[i].pop_front();
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          busy_cnt;
    logic [63:0] a;
    logic [63:0] b;
    logic        s;

    rst_n = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      start_a[i]   = 1'b0;
      sgn_a[i]     = 1'b0;
      in1_a[i]     = '0;
      in2_a[i]     = '0;
      last_prod[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NUM; i++) begin
      checkOutput("reset_busy", i, 128'(busy_a[i]), 128'(0));
      checkOutput("reset_done", i, 128'(done_a[i]), 128'(0));
      checkOutput("reset_prod", i, prod_a[i], 128'(0));
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] W=32 unsigned all-ones, busy duration");
    applyStimulus(I32, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 128'hFFFF_FFFE_0000_0001);
    busy_cnt = 0;
    @(negedge clk);
    start_a[I32] = 1'b0;
    if (busy_a[I32] === 1'b1) busy_cnt++;
    repeat (39) begin
      @(negedge clk);
      if (busy_a[I32] === 1'b1) busy_cnt++;
    end
    checkOutput("busy_cycles", I32, 128'(busy_cnt), 128'(33));

    $display("[TB] W=32 signed and unsigned -7 * 6");
    runOp(I32, 64'hFFFF_FFF9, 64'h6, 1'b1, 128'hFFFF_FFFF_FFFF_FFD6);
    runOp(I32, 64'hFFFF_FFF9, 64'h6, 1'b0, 128'h0000_0005_FFFF_FFD6);

    $display("[TB] W=8 most-negative operands");
    runOp(I8, 64'h80, 64'h80, 1'b1, 128'h4000);
    runOp(I8, 64'h80, 64'h7F, 1'b1, 128'hC080);

    $display("[TB] W=8 start during CALC is ignored, product holds while idle");
    applyStimulus(I8, 64'h05, 64'h09, 1'b0, 128'h2D);
    @(negedge clk);
    start_a[I8] = 1'b0;
    repeat (3) @(negedge clk);
    in1_a[I8]   = 64'hFF;
    in2_a[I8]   = 64'hFF;
    sgn_a[I8]   = 1'b1;
    start_a[I8] = 1'b1;
    @(negedge clk);
    start_a[I8] = 1'b0;
    repeat (5) @(negedge clk);
    repeat (20) @(negedge clk);
    runOp(I8, 64'h0C, 64'h0B, 1'b0, 128'h84);

    $display("[TB] W=8 start held high, operands change per result");
    for (int n = 0; n < 6; n++) begin
      a = randOp(8);
      b = randOp(8);
      s = 1'($urandom_range(0, 1));
      applyStimulus(I8, a, b, s, refProd(8, a, b, s));
      repeat (10) @(negedge clk);
    end
    start_a[I8] = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] W=16 reset during iteration 5");
    applyStimulus(I16, 64'h1234, 64'h5678, 1'b0, refProd(16, 64'h1234, 64'h5678, 1'b0));
    @(negedge clk);
    start_a[I16] = 1'b0;
    repeat (5) @(posedge clk);
    #2 assertReset();
    #1;
    checkOutput("abort_busy", I16, 128'(busy_a[I16]), 128'(0));
    checkOutput("abort_done", I16, 128'(done_a[I16]), 128'(0));
    checkOutput("abort_prod", I16, prod_a[I16], 128'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    runOp(I16, 64'd3, 64'd5, 1'b0, 128'd15);

    $display("[TB] random regression over all widths and both modes");
    for (int i = 0; i < NUM; i++) begin
      repeat (24) begin
        a = randOp(WL[i]);
        b = randOp(WL[i]);
        s = 1'($urandom_range(0, 1));
        runOp(i, a, b, s, refProd(WL[i], a, b, s));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < NUM; i++) begin
      checkOutput("queue_drained", i, 128'(expq[i].size()), 128'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
